// File: rtl/varray_pkg.sv
// Shared definitions for both ends of the virtual array queue (packer and varray).
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package varray_pkg;

    localparam int VIRTUAL_ELEMENT_WIDTH = 18;
    localparam int VIRTUAL_ADDR_BITS     = 16;
    localparam int MAX_RUN               = 31;
    localparam int LEN_BITS              = 5;

    // One run entry as presented on the varray write port.
    typedef struct packed {
        logic [VIRTUAL_ADDR_BITS-1:0]     addr;
        logic [LEN_BITS-1:0]              len;
        logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat;
    } varray_entry_t;

    // First address past a run, wrapped to the address width (this is what varray_len tracks).
    function automatic logic [VIRTUAL_ADDR_BITS-1:0] entry_end(input varray_entry_t e);
        return e.addr + VIRTUAL_ADDR_BITS'(e.len);
    endfunction

endpackage

// File: rtl/varray_entry_reg.sv
// Single-entry valid/ready output register holding one varray_entry_t.
// Latency: a load is visible on the outputs the cycle after it is presented.
// Backpressure: contents held while o_out_vld && !i_out_rdy; caller only loads when empty or draining.
module varray_entry_reg
    import varray_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load_vld,
    input  varray_entry_t i_load_dat,
    input  logic          i_out_rdy,
    output logic          o_out_vld,
    output varray_entry_t o_out_dat
);

    logic          r_vld;
    varray_entry_t r_dat;

    // Load takes priority over drain so a consume and a new load in one cycle give back-to-back entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_load_vld) begin
            r_vld <= 1'b1;
            r_dat <= i_load_dat;
        end else if (r_vld && i_out_rdy) begin
            r_vld <= 1'b0;
        end
    end

    assign o_out_vld = r_vld;
    assign o_out_dat = r_dat;

endmodule

// File: rtl/varray_rle_packer.sv
// Compacts a strictly increasing (addr, element) stream into non-zero run entries for the varray write port.
// Latency: an entry appears on out_* one cycle after the accept (or flush) that closes its run.
// Backpressure: in_ready drops while a final-run flush is pending or the output entry is stalled by out_ready.
module varray_rle_packer #(
    parameter int VIRTUAL_ELEMENT_WIDTH = varray_pkg::VIRTUAL_ELEMENT_WIDTH,
    parameter int VIRTUAL_ADDR_BITS     = varray_pkg::VIRTUAL_ADDR_BITS,
    parameter int MAX_RUN               = varray_pkg::MAX_RUN
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VIRTUAL_ADDR_BITS-1:0]     in_addr,
    input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_dat,
    input  logic                             in_last,
    output logic                             out_we,
    input  logic                             out_ready,
    output logic [VIRTUAL_ADDR_BITS-1:0]     out_write_addr,
    output logic [4:0]                       out_write_addr_len,
    output logic [VIRTUAL_ELEMENT_WIDTH-1:0] out_dat,
    output logic [VIRTUAL_ADDR_BITS-1:0]     out_end,
    output logic                             error
);

    import varray_pkg::*;

    // Parameters are expected to match varray_pkg, since the entry struct is sized from the package.
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_RUN);

    // Open run and stream-tracking state
    logic                             r_run_open;
    logic [VIRTUAL_ADDR_BITS-1:0]     r_run_start;
    logic [LEN_BITS-1:0]              r_run_len;
    logic [VIRTUAL_ELEMENT_WIDTH-1:0] r_run_dat;
    logic                             r_flush_pending;
    logic [VIRTUAL_ADDR_BITS-1:0]     r_prev_addr;
    logic                             r_prev_valid;
    logic                             r_error;
    logic [VIRTUAL_ADDR_BITS-1:0]     r_out_end;

    // Next-state values
    logic                             w_run_open_nxt;
    logic [VIRTUAL_ADDR_BITS-1:0]     w_run_start_nxt;
    logic [LEN_BITS-1:0]              w_run_len_nxt;
    logic [VIRTUAL_ELEMENT_WIDTH-1:0] w_run_dat_nxt;
    logic                             w_flush_pending_nxt;
    logic [VIRTUAL_ADDR_BITS-1:0]     w_prev_addr_nxt;
    logic                             w_prev_valid_nxt;
    logic                             w_error_nxt;

    // Datapath / handshake wires
    logic                             w_out_vld;
    varray_entry_t                    w_out_entry;
    varray_entry_t                    w_load_entry;
    logic                             w_slot_free;
    logic                             w_in_ready;
    logic                             w_acc;
    logic                             w_bad;
    logic                             w_nonzero;
    logic [VIRTUAL_ADDR_BITS:0]       w_run_addr_end;
    logic                             w_extend;
    logic                             w_close;
    logic                             w_flush_load;
    logic                             w_load;
    logic                             w_consume;

    assign w_slot_free  = !w_out_vld || out_ready;
    assign w_in_ready   = !reset && !r_flush_pending && w_slot_free;
    assign w_acc        = in_valid && w_in_ready;
    assign w_consume    = w_out_vld && out_ready;

    assign w_bad        = r_prev_valid && (in_addr <= r_prev_addr);
    assign w_nonzero    = (in_dat != '0);
    // One bit wider than the address so a run ending at the top of the space never matches a wrapped address.
    assign w_run_addr_end = {1'b0, r_run_start} + (VIRTUAL_ADDR_BITS + 1)'(r_run_len);
    assign w_extend     = w_nonzero && r_run_open && (in_dat == r_run_dat) &&
                          ({1'b0, in_addr} == w_run_addr_end) && (r_run_len < MAX_LEN);

    // Any good element that does not extend an open run closes it (zero element or a new run).
    assign w_close      = w_acc && !w_bad && r_run_open && !w_extend;
    // Flush and accept never coincide: in_ready is low while a flush is pending.
    assign w_flush_load = r_flush_pending && w_slot_free;
    assign w_load       = w_close || w_flush_load;

    // Both close and flush move the currently open run into the output register.
    always_comb begin
        w_load_entry      = '0;
        w_load_entry.addr = r_run_start;
        w_load_entry.len  = r_run_len;
        w_load_entry.dat  = r_run_dat;
    end

    // Run-building rules for an accepted element, plus flush completion.
    always_comb begin
        w_run_open_nxt      = r_run_open;
        w_run_start_nxt     = r_run_start;
        w_run_len_nxt       = r_run_len;
        w_run_dat_nxt       = r_run_dat;
        w_flush_pending_nxt = r_flush_pending;
        w_prev_addr_nxt     = r_prev_addr;
        w_prev_valid_nxt    = r_prev_valid;
        w_error_nxt         = r_error;

        if (w_flush_load) begin
            w_run_open_nxt      = 1'b0;
            w_flush_pending_nxt = 1'b0;
            w_prev_valid_nxt    = 1'b0;
        end

        if (w_acc) begin
            if (w_bad) begin
                // Out-of-order element is dropped, but in_last must still end the stream.
                w_error_nxt = 1'b1;
                if (in_last) begin
                    if (r_run_open) begin
                        w_flush_pending_nxt = 1'b1;
                    end else begin
                        w_prev_valid_nxt = 1'b0;
                    end
                end
            end else begin
                w_prev_addr_nxt  = in_addr;
                w_prev_valid_nxt = 1'b1;
                if (!w_nonzero) begin
                    w_run_open_nxt = 1'b0;
                end else if (w_extend) begin
                    w_run_len_nxt = r_run_len + 5'd1;
                end else begin
                    w_run_open_nxt  = 1'b1;
                    w_run_start_nxt = in_addr;
                    w_run_len_nxt   = 5'd1;
                    w_run_dat_nxt   = in_dat;
                end
                // A run is open after a non-zero element; otherwise the stream is already complete.
                if (in_last) begin
                    if (w_nonzero) begin
                        w_flush_pending_nxt = 1'b1;
                    end else begin
                        w_prev_valid_nxt = 1'b0;
                    end
                end
            end
        end
    end

    // State registers; reset discards any open run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_open      <= 1'b0;
            r_run_start     <= '0;
            r_run_len       <= '0;
            r_run_dat       <= '0;
            r_flush_pending <= 1'b0;
            r_prev_addr     <= '0;
            r_prev_valid    <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_run_open      <= w_run_open_nxt;
            r_run_start     <= w_run_start_nxt;
            r_run_len       <= w_run_len_nxt;
            r_run_dat       <= w_run_dat_nxt;
            r_flush_pending <= w_flush_pending_nxt;
            r_prev_addr     <= w_prev_addr_nxt;
            r_prev_valid    <= w_prev_valid_nxt;
            r_error         <= w_error_nxt;
        end
    end

    // out_end follows the end of each entry the consumer actually takes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_end <= '0;
        end else if (w_consume) begin
            r_out_end <= entry_end(w_out_entry);
        end
    end

    varray_entry_reg u_entry_reg (
        .clk        (clk),
        .reset      (reset),
        .i_load_vld (w_load),
        .i_load_dat (w_load_entry),
        .i_out_rdy  (out_ready),
        .o_out_vld  (w_out_vld),
        .o_out_dat  (w_out_entry)
    );

    assign in_ready           = w_in_ready;
    assign out_we             = w_out_vld;
    assign out_write_addr     = w_out_entry.addr;
    assign out_write_addr_len = w_out_entry.len;
    assign out_dat            = w_out_entry.dat;
    assign out_end            = r_out_end;
    assign error              = r_error;

endmodule

// File: doc/varray_rle_packer.md
Name: varray_rle_packer

Overview:
- Write-side producer for the virtual array queue.
- Takes a dense stream of (addr, element) with strictly increasing addresses and compacts it into run entries (write_addr, write_addr_len, dat). Each entry feeds the varray write port directly.
- Zero elements are never stored; they become gaps that the varray reader returns as 0.
- Sits between a compute/store stage and the varray write interface.

Parameters:
- VIRTUAL_ELEMENT_WIDTH, 18, element data width
- VIRTUAL_ADDR_BITS, 16, virtual address width
- MAX_RUN, 31, maximum run length; must fit the 5-bit length field

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input element valid
- in_ready  out  1  packer accepts element this cycle
- in_addr  in  VIRTUAL_ADDR_BITS  element virtual address
- in_dat  in  VIRTUAL_ELEMENT_WIDTH  element value
- in_last  in  1  final element of stream; forces close of open run
- out_we  out  1  run entry valid
- out_ready  in  1  consumer takes entry; tie 1 for direct varray hookup
- out_write_addr  out  VIRTUAL_ADDR_BITS  run start address
- out_write_addr_len  out  5  run length, 1..MAX_RUN
- out_dat  out  VIRTUAL_ELEMENT_WIDTH  run value, never 0
- out_end  out  VIRTUAL_ADDR_BITS  start+len of last emitted entry; mirrors varray_len
- error  out  1  sticky: non-monotonic address seen

Behaviour:
- Handshakes
  - Input accept when in_valid && in_ready.
  - Output consumed when out_we && out_ready.
  - in_ready = !reset && !flush_pending && (!out_we || out_ready).
- Internal state
  - Open run: run_open, run_start, run_len, run_dat.
  - Output register: out_we plus its fields.
  - flush_pending flag.
  - prev_addr and prev_valid.
- Per accepted element (addr a, data d):
  - a <= prev_addr while prev_valid: set error, drop the element, state unchanged except that in_last still triggers a close.
  - d == 0: close the open run if any. No new run.
  - Extend run_len+1 when all hold: d != 0, run_open, d == run_dat, a == run_start+run_len (computed VIRTUAL_ADDR_BITS+1 wide, with no extension across the address wrap), and run_len < MAX_RUN.
  - Otherwise, if d != 0: close the open run if any, then open {a, 1, d}.
  - in_last also accepted: if a run is open after the above, set flush_pending. Clear prev_valid after the flush completes so a new stream may restart at any address.
- Close means load the run into the output register the next cycle (out_we=1) and clear run_open. The output register is guaranteed free by in_ready.
- flush_pending
  - Moves the open run to the output register on the first cycle the output slot is free or drained; then clears.
  - in_ready is low while it is set.
- Latency: an entry appears on out_* one cycle after the accept that closes it.
- Output hold: out_* are held stable while out_we && !out_ready.
- out_end updates to out_write_addr+out_write_addr_len on each consumed entry, truncated to VIRTUAL_ADDR_BITS.
- Reset:
  - out_we, all out_* fields, out_end, error, run_open, flush_pending and prev_valid go to 0.
  - A reset mid-run discards the open run and any pending entry; nothing is emitted.
- Simultaneous events: output consumed and a new close in the same cycle is legal; the new entry is loaded back-to-back, giving full throughput of one element per cycle.

Decomposition:
- Shared package varray_pkg holds:
  - VIRTUAL_ELEMENT_WIDTH, VIRTUAL_ADDR_BITS, MAX_RUN
  - varray_entry_t typedef struct {addr, len[4:0], dat}
  - Reuse it in varray to keep both ends consistent.
- One natural sub-module, varray_entry_reg: a single-entry valid/ready output register holding varray_entry_t.

Test Plan:
- addr 0..4, dat 7,7,7,0,5, in_last on addr 4 -> entries (0,3,7) then (4,1,5); out_end=5.
- 40 consecutive dat=3 from addr 100, in_last on last -> (100,31,3) then (131,9,3).
- addr 10 dat 2, addr 12 dat 2 (gap), in_last -> (10,1,2),(12,1,2); no merge across gap.
- Entry pending with out_ready=0 for 5 cycles -> in_ready=0, out_* stable; on release the entry is consumed and in_ready returns to 1 next cycle.
- addr 20 dat 1 then addr 20 dat 1 -> error=1 stays set; second element dropped; run len stays 1.
- addr 0..2 dat 9, reset high at cycle 3 -> no out_we ever asserted; all outputs 0; stream restarts cleanly at addr 0.
